// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
// Holds the FSM state encoding and the skid FIFO depth.
package ram_stream_reader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Two-entry register FIFO that absorbs the RAM read latency.
// The head register drives the stream output directly.
module stream_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [1:0]            count_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  assign dout_o  = head_q;
  assign count_o = cnt_q;
  assign valid_o = (cnt_q != 2'd0);

  // Next-state: shift tail into head on pop, land new data behind the head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_i) begin
          head_d = din_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        case ({push_i, pop_ok})
          2'b10: begin
            tail_d = din_i;
            cnt_d  = 2'd2;
          end
          2'b01: cnt_d = 2'd0;
          2'b11: head_d = din_i;
          default: ;
        endcase
      end
      2'd2: begin
        if (pop_ok) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = din_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Storage and occupancy registers, cleared by the shared reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a run of RAM addresses and streams the words out
// on a valid/ready interface through a 2-entry skid FIFO.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iBaseAddress,
  input  logic [LEN_WIDTH-1:0]  iLength,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [DATA_WIDTH-1:0] iRamData,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oBusy,
  output logic                  oDone
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [LEN_WIDTH-1:0]  popcnt_q;
  logic                  infl_q;
  logic                  done_q;

  logic [1:0] fcnt;
  logic       fvalid;
  logic       pop;
  logic       issue;
  logic [2:0] occ;

  assign pop   = fvalid & iReady;
  // Slots already claimed, counting the word still coming out of the RAM.
  assign occ   = {1'b0, fcnt} + {2'b00, infl_q} - {2'b00, pop};
  assign issue = (state_q == ST_RUN) && (rem_q != '0)
              && (occ < 3'(FIFO_DEPTH));

  assign oReadAddress = addr_q;
  assign oBusy        = (state_q == ST_RUN);
  assign oDone        = done_q;
  assign oValid       = fvalid;

  stream_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .push_i (infl_q),
    .pop_i  (pop),
    .din_i  (iRamData),
    .dout_o (oData),
    .count_o(fcnt),
    .valid_o(fvalid)
  );

  // Control FSM with address, issue and completion counters.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      popcnt_q <= '0;
      infl_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      infl_q <= issue;
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            if (iLength != '0) begin
              state_q  <= ST_RUN;
              addr_q   <= iBaseAddress;
              rem_q    <= iLength;
              popcnt_q <= iLength;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            rem_q  <= rem_q - LEN_WIDTH'(1);
          end
          if (pop) begin
            popcnt_q <= popcnt_q - LEN_WIDTH'(1);
            if (popcnt_q == LEN_WIDTH'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
